wave_display: RTL and testbench

WAVE_DISPLAY -- requirements
Module: wave_display

---
 rtl/wave_pkg.sv | 31 +++
 rtl/wave_pixel_test.sv | 33 +++
 rtl/wave_display.sv | 108 ++++++++++
 tb/tb_wave_display.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
// Shared constants and types for the waveform display pipeline.
//   SAMPLE_W / RAM_ADDR_W : sample width and sample RAM address width
//   WIN_X / WIN_Y         : size of the waveform window in pixels
//   COLOR_*               : 8-bit intensities for trace, background, grid
//   stage1_t              : fields carried from the input stage to the
//                           colour stage
// ---------------------------------------------------------------------------
package wave_pkg;

    localparam int unsigned SAMPLE_W   = 8;
    localparam int unsigned RAM_ADDR_W = 9;
    localparam int unsigned WIN_X      = 512;
    localparam int unsigned WIN_Y      = 512;

    localparam logic [7:0] COLOR_FG   = 8'hFF;
    localparam logic [7:0] COLOR_BG   = 8'h00;
    localparam logic [7:0] COLOR_GRID = 8'h40;

    // Stage-1 pixel context. Only row = y[8:1] is kept from y because
    // the window compare has already been folded into in_win.
    typedef struct packed {
        logic [10:0]         x;
        logic [SAMPLE_W-1:0] row;
        logic                grid;
        logic                valid;
        logic                in_win;
    } stage1_t;

endpackage

// File: rtl/wave_pixel_test.sv
// ---------------------------------------------------------------------------
// wave_pixel_test
// Decides whether a pixel row lies on the trace segment between two
// consecutive samples and picks the matching colour.
//   i_prev, i_cur : endpoints of the segment (unsigned samples)
//   i_row         : pixel row in sample units (y[8:1])
//   i_grid_hit    : pixel sits on a grid line
//   o_lit         : row is within [min, max] of the endpoints, inclusive
//   o_colour      : trace, grid or background intensity
// ---------------------------------------------------------------------------
module wave_pixel_test
    import wave_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_prev,
    input  logic [SAMPLE_W-1:0] i_cur,
    input  logic [SAMPLE_W-1:0] i_row,
    input  logic                i_grid_hit,
    output logic                o_lit,
    output logic [7:0]          o_colour
);

    logic [SAMPLE_W-1:0] w_lo;
    logic [SAMPLE_W-1:0] w_hi;

    always_comb begin
        w_lo     = (i_prev < i_cur) ? i_prev : i_cur;
        w_hi     = (i_prev < i_cur) ? i_cur  : i_prev;
        o_lit    = (i_row >= w_lo) && (i_row <= w_hi);
        o_colour = o_lit      ? COLOR_FG   :
                   i_grid_hit ? COLOR_GRID : COLOR_BG;
    end

endmodule

// File: rtl/wave_display.sv
// ---------------------------------------------------------------------------
// wave_display
// Draws the captured waveform into a 512x512 window of the VGA raster.
// Each RAM sample covers two pixel columns; consecutive samples are joined
// by a vertical segment so steep edges stay connected.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   x, y, valid        : raster position and visible-area flag
//   read_index         : RAM half most recently filled by wave_capture
//   read_address       : sample RAM address {latched index, x[8:1]}
//   read_value         : sample RAM data, one cycle after read_address
//   valid_pixel, r/g/b : pixel output, 2 cycles after x/y/valid
//   wave_display_idle  : raster is below the waveform band (y >= 512)
//
// Build option: define WAVE_DISPLAY_GRID_EN to draw a grid every 64 pixels
// on unlit in-window pixels.
// ---------------------------------------------------------------------------
module wave_display
    import wave_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           x,
    input  logic [9:0]            y,
    input  logic                  valid,
    input  logic                  read_index,
    output logic [RAM_ADDR_W-1:0] read_address,
    input  logic [SAMPLE_W-1:0]   read_value,
    output logic                  valid_pixel,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b,
    output logic                  wave_display_idle
);

    stage1_t             r_s1;
    logic [SAMPLE_W-1:0] r_prev;
    logic                r_idx;
    logic                r_idle;
    logic [7:0]          r_colour;
    logic                r_valid_pixel;

    logic                w_in_win;
    logic                w_grid;
    logic [SAMPLE_W-1:0] w_prev_eff;
    logic                w_lit;
    logic [7:0]          w_colour;

    always_comb begin
        w_in_win = valid && (x < 11'(WIN_X)) && (y < 10'(WIN_Y));
`ifdef WAVE_DISPLAY_GRID_EN
        w_grid   = (x[5:0] == '0) || (y[5:0] == '0);
`else
        w_grid   = 1'b0;
`endif
        // Column 0 starts a fresh line: no segment from the previous row.
        w_prev_eff = (r_s1.x == '0) ? read_value : r_prev;
    end

    assign read_address = {r_idx, x[8:1]};

    wave_pixel_test u_pixel_test (
        .i_prev     (w_prev_eff),
        .i_cur      (read_value),
        .i_row      (r_s1.row),
        .i_grid_hit (r_s1.grid),
        .o_lit      (w_lit),
        .o_colour   (w_colour)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1          <= '0;
            r_prev        <= '0;
            r_idx         <= 1'b0;
            r_idle        <= 1'b0;
            r_colour      <= COLOR_BG;
            r_valid_pixel <= 1'b0;
        end else begin
            r_s1.x      <= x;
            r_s1.row    <= y[8:1];
            r_s1.grid   <= w_grid;
            r_s1.valid  <= valid;
            r_s1.in_win <= w_in_win;

            // prev follows the sample of the right-hand column of each pair.
            if (r_s1.in_win && r_s1.x[0])
                r_prev <= read_value;

            // Buffer index may only change while outside the waveform band.
            if (r_idle)
                r_idx <= read_index;
            r_idle <= (y >= 10'(WIN_Y));

            r_colour      <= !r_s1.in_win ? COLOR_BG :
                             (w_lit ? COLOR_FG : w_colour);
            r_valid_pixel <= r_s1.valid;
        end
    end

    assign r                 = r_colour;
    assign g                 = r_colour;
    assign b                 = r_colour;
    assign valid_pixel       = r_valid_pixel;
    assign wave_display_idle = r_idle;

endmodule

// File: tb/tb_wave_display.sv
module tb_wave_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [8:0]  read_address;
    logic [7:0]  read_value;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic        wave_display_idle;

`ifdef WAVE_DISPLAY_GRID_EN
    localparam bit GRID_ON = 1'b1;
`else
    localparam bit GRID_ON = 1'b0;
`endif
    localparam logic [7:0] GRID_C = GRID_ON ? 8'h40 : 8'h00;

    int checks = 0;
    int errors = 0;

    wave_display dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
        .y                 (y),
        .valid             (valid),
        .read_index        (read_index),
        .read_address      (read_address),
        .read_value        (read_value),
        .valid_pixel       (valid_pixel),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .wave_display_idle (wave_display_idle)
    );

    always #5 clk = ~clk;

    // Synchronous sample RAM
    logic [7:0] ram [0:511];
    always @(posedge clk) read_value <= ram[read_address];

    // Reference model state (spec-level view of the pixel stream)
    int m_prev = 0;
    int m_idx  = 0;
    bit m_idle = 0;
    bit m_s1_alive = 0;
    int m_s1_x = 0, m_s1_y = 0, m_s1_cur = 0;
    bit m_s1_v = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // One raster cycle: drive inputs, step the model across the clock edge
    // and compare every output against it.
    task automatic cyc(input bit rst, input bit v, input int px, input int py, input bit ri);
        int addr, exp_c, pe, lo, hi, row;
        bit exp_vp, inw;
        @(negedge clk);
        reset = rst; valid = v; x = px[10:0]; y = py[9:0]; read_index = ri;
        #1;
        addr = m_idx * 256 + ((px / 2) % 256);
        check("addr", read_address, addr);
        @(posedge clk);
        #1;
        exp_c = 0;
        exp_vp = 0;
        if (!rst && m_s1_alive) begin
            inw = m_s1_v && m_s1_x < 512 && m_s1_y < 512;
            pe  = (m_s1_x == 0) ? m_s1_cur : m_prev;
            row = m_s1_y / 2;
            lo  = (pe < m_s1_cur) ? pe : m_s1_cur;
            hi  = (pe < m_s1_cur) ? m_s1_cur : pe;
            if (inw && row >= lo && row <= hi)
                exp_c = 255;
            else if (inw && GRID_ON && (m_s1_x % 64 == 0 || m_s1_y % 64 == 0))
                exp_c = 64;
            exp_vp = m_s1_v;
            if (inw && (m_s1_x % 2 == 1))
                m_prev = m_s1_cur;
        end
        if (rst) m_prev = 0;
        m_s1_alive = !rst;
        m_s1_x = px; m_s1_y = py; m_s1_v = v; m_s1_cur = ram[addr];
        if (rst) begin
            m_idx = 0; m_idle = 0;
        end else begin
            if (m_idle) m_idx = ri;
            m_idle = (py >= 512);
        end
        check("rgb", {r, g, b}, {exp_c[7:0], exp_c[7:0], exp_c[7:0]});
        check("valid_pixel", valid_pixel, exp_vp);
        check("idle", wave_display_idle, m_idle);
    endtask

    typedef struct {
        int         x;
        int         y;
        bit         v;
        int         p;
        int         c;
        logic [7:0] exp;
        bit         vp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int vx, int vy, bit vv, int vp_s, int vc, logic [7:0] ve, bit vvp);
        vec_t t;
        t.x = vx; t.y = vy; t.v = vv; t.p = vp_s; t.c = vc; t.exp = ve; t.vp = vvp;
        return t;
    endfunction

    // Preceding odd in-window column carries prev; x=0 uses column 511 to
    // prove that the previous row's sample is ignored.
    task automatic run_vec(input vec_t t, input int n);
        int xp;
        xp = (t.x == 0) ? 511 : ((t.x % 2 == 0) ? t.x - 1 : t.x - 2);
        ram[(xp / 2) % 256]       = t.p[7:0];
        ram[256 + (xp / 2) % 256] = t.p[7:0];
        ram[(t.x / 2) % 256]       = t.c[7:0];
        ram[256 + (t.x / 2) % 256] = t.c[7:0];
        cyc(0, 1, xp, 0, 0);
        cyc(0, t.v, t.x, t.y, 0);
        cyc(0, 0, 0, 0, 0);
        check($sformatf("vec%0d_rgb", n), r, t.exp);
        check($sformatf("vec%0d_vp", n), valid_pixel, t.vp);
    endtask

    initial begin
        int xs, ys;
        reset = 1'b1; valid = 1'b0; x = '0; y = '0; read_index = 1'b0;
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;

        vecs.push_back(mk(10,  20,  1, 10,  10,  8'hFF, 1)); // latency
        vecs.push_back(mk(3,   80,  1, 40,  60,  8'hFF, 1)); // slope low end
        vecs.push_back(mk(3,   120, 1, 40,  60,  8'hFF, 1)); // slope high end
        vecs.push_back(mk(3,   100, 1, 40,  60,  8'hFF, 1)); // slope middle
        vecs.push_back(mk(3,   78,  1, 40,  60,  8'h00, 1)); // row 39
        vecs.push_back(mk(3,   122, 1, 40,  60,  8'h00, 1)); // row 61
        vecs.push_back(mk(4,   100, 1, 60,  40,  8'hFF, 1)); // falling slope
        vecs.push_back(mk(0,   60,  1, 90,  30,  8'hFF, 1)); // line start, row=cur
        vecs.push_back(mk(0,   62,  1, 90,  30,  GRID_C, 1)); // line start, row=cur+1
        vecs.push_back(mk(64,  300, 1, 10,  20,  GRID_C, 1)); // grid column
        vecs.push_back(mk(600, 20,  1, 10,  10,  8'h00, 1)); // right of window
        vecs.push_back(mk(100, 600, 1, 255, 255, 8'h00, 1)); // below window
        vecs.push_back(mk(10,  20,  0, 10,  10,  8'h00, 0)); // blanking
        vecs.push_back(mk(20,  511, 1, 255, 255, 8'hFF, 1)); // last row

        repeat (3) cyc(1, 0, 0, 0, 0);
        check("reset_rgb", {r, g, b}, 0);
        check("reset_vp", valid_pixel, 0);
        check("reset_idle", wave_display_idle, 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Buffer swap: index must hold inside the waveform band
        cyc(0, 1, 100, 100, 0);
        cyc(0, 1, 101, 100, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 102 + i, 100, i[0]);
            check("swap_hold", read_address[8], 0);
        end
        cyc(0, 1, 120, 600, 1);
        check("swap_idle", wave_display_idle, 1);
        cyc(0, 1, 121, 100, 1);
        check("swap_msb", read_address[8], 1);
        cyc(0, 1, 122, 100, 0);
        check("swap_msb_hold", read_address[8], 1);

        // Reset mid-line
        ram[4] = 8'd10; ram[5] = 8'd10; ram[260] = 8'd10; ram[261] = 8'd10;
        cyc(0, 1, 198, 50, 0);
        cyc(0, 1, 199, 600, 0);
        cyc(1, 1, 200, 50, 0);
        check("rst_mid_rgb", {r, g, b}, 0);
        check("rst_mid_vp", valid_pixel, 0);
        check("rst_mid_idle", wave_display_idle, 0);
        cyc(1, 1, 201, 50, 0);
        check("rst_mid_rgb2", {r, g, b}, 0);
        cyc(0, 1, 10, 20, 0);
        check("post_rst_early_vp", valid_pixel, 0);
        cyc(0, 0, 11, 20, 0);
        check("post_rst_rgb", r, 8'hFF);
        check("post_rst_vp", valid_pixel, 1);

        // Randomised raster traffic against the model
        for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
        xs = 0;
        ys = $urandom_range(0, 700);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) xs = $urandom_range(0, 799);
            else if (xs >= 799) begin
                xs = 0;
                ys = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 700) : (ys + 1) % 701;
            end else xs = xs + 1;
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                xs, ys, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
